// File: rtl/component_counter_pkg.sv
// Shared definitions for the component counter.
//   FUNC_WIDTH    : truth-table width of a 7-variable function (bit i = vertex i)
//   state_t       : FSM state encoding (IDLE, SEED, EXPAND, DONE)
//   monotonizeUp  : upward closure of a vertex set over the 7-cube
//   monotonizeDown: downward closure of a vertex set over the 7-cube
package component_counter_pkg;

    localparam int FUNC_WIDTH = 128;
    localparam int NUM_VARS   = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } state_t;

    // A vertex joins the result if any vertex below it (by subset of its
    // index bits) is in f. Closing one variable at a time is enough: the
    // source index of pass j has bit j clear, so it is never rewritten in
    // the same pass.
    function automatic logic [FUNC_WIDTH-1:0] monotonizeUp(input logic [FUNC_WIDTH-1:0] f);
        logic [FUNC_WIDTH-1:0] r;
        r = f;
        for (int j = 0; j < NUM_VARS; j++) begin
            for (int i = 0; i < FUNC_WIDTH; i++) begin
                if (((i >> j) & 1) != 0) begin
                    r[i] = r[i] | r[i ^ (1 << j)];
                end
            end
        end
        return r;
    endfunction

    // Mirror image: a vertex joins if any vertex above it is in f.
    function automatic logic [FUNC_WIDTH-1:0] monotonizeDown(input logic [FUNC_WIDTH-1:0] f);
        logic [FUNC_WIDTH-1:0] r;
        r = f;
        for (int j = 0; j < NUM_VARS; j++) begin
            for (int i = 0; i < FUNC_WIDTH; i++) begin
                if (((i >> j) & 1) == 0) begin
                    r[i] = r[i] | r[i | (1 << j)];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/component_counter_first_bit_select.sv
// Isolates the lowest set bit of a 128-bit vector.
//   vec    : input vector
//   oneHot : one-hot copy of the lowest set bit of vec, all-zero when vec is zero
module first_bit_select
    import component_counter_pkg::*;
(
    input  logic [FUNC_WIDTH-1:0] vec,
    output logic [FUNC_WIDTH-1:0] oneHot
);

    // Two's complement trick: vec & -vec keeps only the lowest set bit.
    assign oneHot = vec & (~vec + {{(FUNC_WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/component_counter.sv
// Counts connected components of a 128-vertex graph on the 7-cube.
// Two vertices are adjacent when comparable; each component is flood-filled
// from its lowest vertex by alternating upward and downward closure.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : graph input handshake; in_ready is high only while idle
//   graph_in             : graph to decompose
//   out_valid / out_ready: result handshake; count_out is held until out_ready
//   count_out            : number of components
//   dbgState             : current FSM state (state_t encoding)
// Handshake rule: a word moves on a rising edge where valid and ready are
// both high; a producer holds valid and data stable until that edge.
module component_counter
    import component_counter_pkg::*;
#(
    parameter int COUNT_WIDTH = 7,
    parameter bit REG_MID     = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FUNC_WIDTH-1:0]  graph_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] count_out,
    output logic [1:0]             dbgState
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    state_t                  state;
    logic [FUNC_WIDTH-1:0]   remaining;
    logic [FUNC_WIDTH-1:0]   x;
    logic [COUNT_WIDTH-1:0]  count;
    logic                    midPhase;

    logic [FUNC_WIDTH-1:0]   seedBit;
    logic [FUNC_WIDTH-1:0]   upPart;
    logic [FUNC_WIDTH-1:0]   downSrc;
    logic [FUNC_WIDTH-1:0]   xNext;
    logic                    stepReady;

    first_bit_select u_firstBit (
        .vec    (remaining),
        .oneHot (seedBit)
    );

    assign upPart = remaining & monotonizeUp(x);

    // With REG_MID the upward half is registered. The register loads every
    // cycle; x and remaining are frozen during the first EXPAND phase, so
    // the value seen in the second phase belongs to the current x.
    generate
        if (REG_MID) begin : g_midReg
            logic [FUNC_WIDTH-1:0] midReg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    midReg <= '0;
                end else begin
                    midReg <= upPart;
                end
            end
            assign downSrc   = midReg;
            assign stepReady = midPhase;
        end else begin : g_noMidReg
            assign downSrc   = upPart;
            assign stepReady = 1'b1;
        end
    endgenerate

    assign xNext    = remaining & monotonizeDown(downSrc);
    assign dbgState = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            x         <= '0;
            count     <= '0;
            midPhase  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        remaining <= graph_in;
                        count     <= '0;
                        in_ready  <= 1'b0;
                        state     <= SEED;
                    end
                end
                SEED: begin
                    midPhase <= 1'b0;
                    if (remaining == '0) begin
                        out_valid <= 1'b1;
                        count_out <= count;
                        state     <= DONE;
                    end else begin
                        x     <= seedBit;
                        state <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (!stepReady) begin
                        midPhase <= 1'b1;
                    end else begin
                        midPhase <= 1'b0;
                        if (xNext == x) begin
                            // Fixpoint: x is a whole component.
                            remaining <= remaining & ~x;
                            if (count != COUNT_MAX) begin
                                count <= count + 1'b1;
                            end
                            state <= SEED;
                        end else begin
                            x <= xNext;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_component_counter.sv
module tb_component_counter;

  localparam int CW = 7;
  localparam int FW = 128;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: REG_MID=0 instance, index 1: REG_MID=1 instance
  logic          in_valid_s  [2];
  logic          in_ready_s  [2];
  logic [FW-1:0] graph_s     [2];
  logic          out_valid_s [2];
  logic          out_ready_s [2];
  logic [CW-1:0] count_s     [2];
  logic [1:0]    state_s     [2];

  component_counter #(.COUNT_WIDTH(CW), .REG_MID(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .graph_in(graph_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .count_out(count_s[0]),
    .dbgState(state_s[0])
  );

  component_counter #(.COUNT_WIDTH(CW), .REG_MID(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .graph_in(graph_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .count_out(count_s[1]),
    .dbgState(state_s[1])
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [CW-1:0] exp_q[$];

  // ---------------- reference model: union-find over comparable pairs ----------------
  function automatic logic [CW-1:0] ref_count(input logic [FW-1:0] g);
    int par[FW];
    int n;
    int ri;
    int rj;
    for (int i = 0; i < FW; i++) par[i] = i;
    for (int i = 0; i < FW; i++) begin
      for (int j = i + 1; j < FW; j++) begin
        if (g[i] && g[j] && (((i & j) == i) || ((i & j) == j))) begin
          ri = i;
          while (par[ri] != ri) ri = par[ri];
          rj = j;
          while (par[rj] != rj) rj = par[rj];
          if (ri != rj) par[rj] = ri;
        end
      end
    end
    n = 0;
    for (int i = 0; i < FW; i++) begin
      if (g[i] && par[i] == i) n++;
    end
    if (n > (1 << CW) - 1) n = (1 << CW) - 1;
    return n[CW-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      in_valid_s[s]  = 1'b0;
      out_ready_s[s] = 1'b0;
      graph_s[s]     = '0;
    end
    step(2);
    rst = 1'b0;
  endtask

  // Offers g to DUT s; returns #1 after the accepting edge.
  task automatic send(input int s, input logic [FW-1:0] g, input bit push);
    int w;
    w = 0;
    while (!in_ready_s[s] && w < 300) begin
      step(1);
      w++;
    end
    n_checks++;
    if (in_ready_s[s] !== 1'b1)
      $display("FAIL send_ready dut%0d: in_ready=%0b expected 1", s, in_ready_s[s]);
    else
      n_pass++;
    in_valid_s[s] = 1'b1;
    graph_s[s]    = g;
    if (push) exp_q.push_back(ref_count(g));
    step(1);
    in_valid_s[s] = 1'b0;
  endtask

  // Waits for a result, compares against the scoreboard, holds out_ready low
  // for `hold` cycles, then completes the handshake.
  task automatic collect(input int s, input int hold, input string name);
    int w;
    logic [CW-1:0] exp;
    w = 0;
    while (!out_valid_s[s] && w < 5000) begin
      step(1);
      w++;
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (out_valid_s[s] !== 1'b1) begin
      $display("FAIL %s_timeout dut%0d: out_valid=%0b expected 1", name, s, out_valid_s[s]);
      return;
    end
    n_pass++;
    n_checks++;
    if (count_s[s] !== exp)
      $display("FAIL %s_count dut%0d: count_out=%0d expected %0d", name, s, count_s[s], exp);
    else
      n_pass++;
    for (int h = 0; h < hold; h++) begin
      step(1);
      n_checks++;
      if (out_valid_s[s] !== 1'b1 || count_s[s] !== exp || in_ready_s[s] !== 1'b0)
        $display("FAIL %s_hold dut%0d cyc%0d: out_valid=%0b count_out=%0d in_ready=%0b expected 1/%0d/0",
                 name, s, h, out_valid_s[s], count_s[s], in_ready_s[s], exp);
      else
        n_pass++;
    end
    out_ready_s[s] = 1'b1;
    step(1);
    out_ready_s[s] = 1'b0;
    n_checks++;
    if (out_valid_s[s] !== 1'b0 || in_ready_s[s] !== 1'b1)
      $display("FAIL %s_release dut%0d: out_valid=%0b in_ready=%0b expected 0/1",
               name, s, out_valid_s[s], in_ready_s[s]);
    else
      n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (in_ready_s[s] !== 1'b1 || out_valid_s[s] !== 1'b0 || count_s[s] !== '0 || state_s[s] !== ST_IDLE)
        $display("FAIL reset dut%0d: in_ready=%0b out_valid=%0b count_out=%0d state=%0d expected 1/0/0/0",
                 s, in_ready_s[s], out_valid_s[s], count_s[s], state_s[s]);
      else
        n_pass++;
    end
  endtask

  // Empty graph: out_valid rises on the second edge counting the accepting one.
  task automatic test_empty_latency(input int s);
    send(s, '0, 1'b1);
    n_checks++;
    if (out_valid_s[s] !== 1'b0)
      $display("FAIL empty_early dut%0d: out_valid=%0b expected 0", s, out_valid_s[s]);
    else
      n_pass++;
    step(1);
    n_checks++;
    if (out_valid_s[s] !== 1'b1)
      $display("FAIL empty_latency dut%0d: out_valid=%0b expected 1", s, out_valid_s[s]);
    else
      n_pass++;
    collect(s, 0, "empty");
  endtask

  task automatic test_directed(input int s);
    logic [FW-1:0] g;
    logic [CW-1:0] want[4];
    logic [FW-1:0] graphs[4];
    graphs[0] = 128'h1;  want[0] = 7'd1;
    graphs[1] = 128'h6;  want[1] = 7'd2;
    graphs[2] = 128'hE;  want[2] = 7'd1;
    g = '0;
    for (int k = 0; k < 7; k++) g[1 << k] = 1'b1;
    graphs[3] = g;       want[3] = 7'd7;
    for (int t = 0; t < 4; t++) begin
      // hand-derived counts double-check the reference model itself
      n_checks++;
      if (ref_count(graphs[t]) !== want[t])
        $display("FAIL model_directed%0d: model=%0d expected %0d", t, ref_count(graphs[t]), want[t]);
      else
        n_pass++;
      send(s, graphs[t], 1'b1);
      collect(s, 0, "directed");
    end
    g = '1;
    send(s, g, 1'b1);
    collect(s, 0, "all_ones");
  endtask

  task automatic test_backpressure();
    send(0, 128'h6, 1'b1);
    collect(0, 10, "backpressure");
  endtask

  task automatic test_abort();
    logic [FW-1:0] g;
    g = '0;
    for (int k = 0; k < 7; k++) g[1 << k] = 1'b1;
    send(0, g, 1'b0);
    step(1);
    n_checks++;
    if (state_s[0] !== ST_EXPAND)
      $display("FAIL abort_in_expand: state=%0d expected %0d", state_s[0], ST_EXPAND);
    else
      n_pass++;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_checks++;
    if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0 || state_s[0] !== ST_IDLE)
      $display("FAIL abort_reset: in_ready=%0b out_valid=%0b state=%0d expected 1/0/0",
               in_ready_s[0], out_valid_s[0], state_s[0]);
    else
      n_pass++;
    send(0, 128'h1, 1'b1);
    collect(0, 0, "after_abort");
  endtask

  task automatic test_random(input int s);
    logic [FW-1:0] g;
    int density;
    for (int t = 0; t < 12; t++) begin
      density = $urandom_range(1, 5);
      for (int b = 0; b < FW; b++) g[b] = ($urandom_range(0, 15) < density);
      send(s, g, 1'b1);
      collect(s, $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty_latency(0);
    test_empty_latency(1);
    test_directed(0);
    test_directed(1);
    test_backpressure();
    test_abort();
    test_random(0);
    test_random(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
